// File: rtl/cpa_pkg.sv
// Shared configuration for the carry-propagate adder pipeline that follows the CSA stage.
package cpa_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  localparam int DEF_CHUNK  = DEF_WIDTH / DEF_STAGES;

  typedef logic [DEF_STAGES-1:0] stage_valid_t;

endpackage

// File: rtl/cpa_pipe_if.sv
// Valid/ready handshake bundle between the CSA stage, the CPA pipeline and its consumer.
// The cout signal exists only when CPA_COUT_EN is defined.
interface cpa_pipe_if
  import cpa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
`ifdef CPA_COUT_EN
  logic             cout;
`endif

  modport master (
    output in_valid,
    output s_in,
    output c_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result
`ifdef CPA_COUT_EN
    , input cout
`endif
  );

  modport slave (
    input  in_valid,
    input  s_in,
    input  c_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result
`ifdef CPA_COUT_EN
    , output cout
`endif
  );

endinterface

// File: rtl/cpa_chunk.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module cpa_chunk
  import cpa_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/cpa_pipe.sv
// Pipelined carry-propagate adder: resolves a CSA sum/carry pair CHUNK bits per stage.
// Optional feature macro CPA_COUT_EN adds a registered carry out aligned with result.
module cpa_pipe
  import cpa_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic       clk,
  input logic       rst,
  cpa_pipe_if.slave bus
);

  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES-1:0] valid_r;
  logic              advance_s;

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign advance_s     = ~valid_r[STAGES-1] | bus.out_ready;
  assign bus.in_ready  = advance_s;
  assign bus.out_valid = valid_r[STAGES-1];

  // Stage valid bits shift together; bubbles travel with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (advance_s) begin
      valid_r <= {valid_r[STAGES-2:0], bus.in_valid};
    end else begin
      valid_r <= valid_r;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k + 1) * CHUNK;
    localparam int HI = WIDTH - k * CHUNK;

    logic [HI-1:0]    hs_in_s;
    logic [HI-1:0]    hc_in_s;
    logic             cin_s;
    logic [CHUNK-1:0] sum_s;
    logic             cout_s;
    logic [LO-1:0]    lo_next_s;
    logic [LO-1:0]    lo_r;

    // hs/hc hold the still-unresolved upper bits; the low chunk feeds this stage's adder.
    if (k == 0) begin : g_src
      assign hs_in_s   = bus.s_in;
      assign hc_in_s   = bus.c_in;
      assign cin_s     = 1'b0;
      assign lo_next_s = sum_s;
    end else begin : g_src
      assign hs_in_s   = g_stage[k-1].g_fwd.hs_r;
      assign hc_in_s   = g_stage[k-1].g_fwd.hc_r;
      assign cin_s     = g_stage[k-1].g_fwd.cy_r;
      assign lo_next_s = {sum_s, g_stage[k-1].lo_r};
    end

    cpa_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a    (hs_in_s[CHUNK-1:0]),
      .b    (hc_in_s[CHUNK-1:0]),
      .cin  (cin_s),
      .sum  (sum_s),
      .cout (cout_s)
    );

    // Resolved low chunks ride along so the full word emerges in one cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        lo_r <= '0;
      end else if (advance_s) begin
        lo_r <= lo_next_s;
      end else begin
        lo_r <= lo_r;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-LO-1:0] hs_r;
      logic [WIDTH-LO-1:0] hc_r;
      logic                cy_r;

      // Skew registers: unprocessed operand chunks plus the inter-stage carry.
      always_ff @(posedge clk) begin
        if (rst) begin
          hs_r <= '0;
          hc_r <= '0;
          cy_r <= 1'b0;
        end else if (advance_s) begin
          hs_r <= hs_in_s[HI-1:CHUNK];
          hc_r <= hc_in_s[HI-1:CHUNK];
          cy_r <= cout_s;
        end else begin
          hs_r <= hs_r;
          hc_r <= hc_r;
          cy_r <= cy_r;
        end
      end
    end else begin : g_top
`ifdef CPA_COUT_EN
      logic cout_r;

      // Carry out of the top chunk, registered alongside the final result.
      always_ff @(posedge clk) begin
        if (rst) begin
          cout_r <= 1'b0;
        end else if (advance_s) begin
          cout_r <= cout_s;
        end else begin
          cout_r <= cout_r;
        end
      end

      assign bus.cout = cout_r;
`else
      logic unused_top_carry_s;
      assign unused_top_carry_s = cout_s;
`endif
    end
  end

  assign bus.result = g_stage[STAGES-1].lo_r;

endmodule

// File: tb/tb_cpa_pipe.sv
// Self-checking bench for cpa_pipe: queue-based reference model plus directed literal checks.
module tb_cpa_pipe;
  import cpa_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int ST = DEF_STAGES;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cpa_pipe_if #(.WIDTH(W)) bus ();

  cpa_pipe #(
    .WIDTH  (W),
    .STAGES (ST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: outstanding sums in order, each with the number of pipe moves it has seen.
  logic [W:0] exp_q[$];
  int         age_q[$];
  bit         chk_en = 1'b0;

  function automatic bit m_valid();
    return (exp_q.size() > 0) && (age_q[0] >= ST);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        exp_q.delete();
        age_q.delete();
        chk_en = 1'b1;
      end else if (chk_en) begin
        if (!m_valid() || bus.out_ready) begin
          if (m_valid()) begin
            void'(exp_q.pop_front());
            void'(age_q.pop_front());
          end
          foreach (age_q[i]) age_q[i] = age_q[i] + 1;
          if (bus.in_valid) begin
            exp_q.push_back({1'b0, bus.s_in} + {1'b0, bus.c_in});
            age_q.push_back(1);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("out_valid", 64'(bus.out_valid), 64'(m_valid()));
        check("in_ready", 64'(bus.in_ready), 64'(!m_valid() || bus.out_ready));
        if (m_valid()) begin
          check("result", 64'(bus.result), 64'(exp_q[0][W-1:0]));
`ifdef CPA_COUT_EN
          check("cout", 64'(bus.cout), 64'(exp_q[0][W]));
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    int first;
    int last;
    int acc;
    int hs;
    logic [W-1:0] first_res;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.s_in      = '0;
    bus.c_in      = '0;
    bus.out_ready = 1'b0;

    // Reset then idle
    step();
    step();
    rst = 1'b0;
    step();
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset result", 64'(bus.result), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
`ifdef CPA_COUT_EN
    check("reset cout", 64'(bus.cout), 64'd0);
`endif

    // Carry across the first chunk boundary
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.s_in      = 32'h0000_00FF;
    bus.c_in      = 32'h0000_0001;
    step();
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("boundary latency", 64'(lat), 64'(ST));
    check("boundary result", 64'(bus.result), 64'h0000_0100);

    // Full carry chain with wrap-around
    bus.in_valid = 1'b1;
    bus.s_in     = 32'hFFFF_FFFF;
    bus.c_in     = 32'h0000_0001;
    step();
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("wrap latency", 64'(lat), 64'(ST));
    check("wrap result", 64'(bus.result), 64'h0000_0000);
`ifdef CPA_COUT_EN
    check("wrap cout", 64'(bus.cout), 64'd1);
`endif

    // Back-to-back stream at full throughput
    seen      = 0;
    first     = -1;
    last      = -1;
    first_res = '0;
    for (int t = 0; t < 16; t++) begin
      if (t < 8) begin
        bus.in_valid = 1'b1;
        bus.s_in     = W'(t) * 32'h1111_1111;
        bus.c_in     = 32'h0101_0101;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (bus.out_valid === 1'b1) begin
        seen++;
        if (first < 0) begin
          first     = t;
          first_res = bus.result;
        end
        last = t;
      end
    end
    check("stream count", 64'(seen), 64'd8);
    check("stream contiguous", 64'(last - first), 64'd7);
    check("stream first cycle", 64'(first), 64'(ST - 1));
    check("stream first result", 64'(first_res), 64'h0101_0101);

    // Backpressure with a full pipe
    bus.out_ready = 1'b0;
    acc = 0;
    for (int g = 0; g < 20 && acc < ST; g++) begin
      bus.in_valid = 1'b1;
      bus.s_in     = $urandom;
      bus.c_in     = $urandom;
      if (bus.in_ready === 1'b1) acc++;
      step();
    end
    check("fill accepted", 64'(acc), 64'(ST));
    bus.s_in = $urandom;
    bus.c_in = $urandom;
    for (int t = 0; t < 3; t++) begin
      step();
      check("stall in_ready", 64'(bus.in_ready), 64'd0);
      check("stall out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    hs = 0;
    for (int t = 0; t < 10; t++) begin
      if (bus.out_valid === 1'b1) hs++;
      step();
    end
    check("drain handshakes", 64'(hs), 64'(ST));

    // Reset with three items in flight
    for (int t = 0; t < 3; t++) begin
      bus.in_valid = 1'b1;
      bus.s_in     = $urandom;
      bus.c_in     = $urandom;
      step();
    end
    rst          = 1'b1;
    bus.s_in     = $urandom;
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      if (bus.out_valid === 1'b1) seen++;
      step();
    end
    check("flushed items", 64'(seen), 64'd0);
    bus.in_valid = 1'b1;
    bus.s_in     = 32'h1234_5678;
    bus.c_in     = 32'h1111_1111;
    step();
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("post-reset latency", 64'(lat), 64'(ST));
    check("post-reset result", 64'(bus.result), 64'h2345_6789);

    // Randomized traffic with random backpressure
    for (int t = 0; t < 400; t++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.s_in      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      bus.c_in      = 32'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2 * ST + 2) step();
    check("final drain out_valid", 64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
